// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM state encodings,
// grant identities and default bus geometry.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W    = 32;
    localparam int ARB_DATA_W    = 32;
    localparam int ARB_MAX_BURST = 6;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_SEND = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic GRANT_PL = 1'b0;
    localparam logic GRANT_MA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle for one memory-port attachment; master issues requests,
// slave accepts them and returns read data.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int AW = ARB_ADDR_W,
    parameter int DW = ARB_DATA_W
) ();

    logic          send_addr_vld;
    logic [AW-1:0] send_addr_dat;
    logic          send_data_vld;
    logic [DW-1:0] send_data_dat;
    logic          send_rdy;
    logic          recv_vld;
    logic [DW-1:0] recv_dat;
    logic          recv_rdy;

    modport master (
        output send_addr_vld, send_addr_dat, send_data_vld, send_data_dat,
        input  send_rdy,
        input  recv_vld, recv_dat,
        output recv_rdy
    );

    modport slave (
        input  send_addr_vld, send_addr_dat, send_data_vld, send_data_dat,
        output send_rdy,
        output recv_vld, recv_dat,
        input  recv_rdy
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick, purely combinational: on contention the requester
// that did not win last time is chosen. req[0] = PL, req[1] = MA.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       any
);

    always_comb begin
        any   = |req;
        grant = GRANT_PL;
        case (req)
            2'b01:   grant = GRANT_PL;
            2'b10:   grant = GRANT_MA;
            2'b11:   grant = (last == GRANT_PL) ? GRANT_MA : GRANT_PL;
            default: grant = GRANT_PL;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between PL and MA, one transaction in flight, 1-cycle arbitration then pass-through;
// stalls follow memory/requester ready. MEM_ARB_BURST_EN lets a requester keep the grant for up to MAX_BURST transfers.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_W,
    parameter int DATA_WIDTH = ARB_DATA_W
`ifdef MEM_ARB_BURST_EN
    ,
    parameter int MAX_BURST  = ARB_MAX_BURST
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  pl_if,
    mem_arbiter_if.slave  ma_if,
    mem_arbiter_if.master mem_if
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q,  last_d;

`ifdef MEM_ARB_BURST_EN
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               xfer_done;
`endif

    logic [1:0] req;
    logic       pick;
    logic       req_any;

    assign req = {ma_if.send_addr_vld, pl_if.send_addr_vld};

    rr_pick2 u_pick (
        .req   (req),
        .last  (last_q),
        .grant (pick),
        .any   (req_any)
    );

    // Granted requester's view, selected by the registered grant only.
    logic                  g_addr_vld;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic                  g_data_vld;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  g_recv_rdy;

    always_comb begin
        g_addr_vld = pl_if.send_addr_vld;
        g_addr     = pl_if.send_addr_dat;
        g_data_vld = pl_if.send_data_vld;
        g_data     = pl_if.send_data_dat;
        g_recv_rdy = pl_if.recv_rdy;
        if (grant_q == GRANT_MA) begin
            g_addr_vld = ma_if.send_addr_vld;
            g_addr     = ma_if.send_addr_dat;
            g_data_vld = ma_if.send_data_vld;
            g_data     = ma_if.send_data_dat;
            g_recv_rdy = ma_if.recv_rdy;
        end
    end

    logic in_send, in_resp;
    logic send_hs, recv_hs;

    assign in_send = (state_q == ARB_SEND);
    assign in_resp = (state_q == ARB_RESP);
    assign send_hs = in_send && g_addr_vld && mem_if.send_rdy;
    assign recv_hs = in_resp && mem_if.recv_vld && g_recv_rdy;

`ifdef MEM_ARB_BURST_EN
    assign xfer_done = (send_hs && g_data_vld) || recv_hs;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (req_any) begin
                    grant_d = pick;
                    state_d = ARB_SEND;
                end
            end
            ARB_SEND: begin
                // A requester withdrawing its request here simply leaves us parked in SEND.
                if (send_hs) begin
                    last_d  = grant_q;
                    state_d = g_data_vld ? ARB_IDLE : ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (recv_hs) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
`ifdef MEM_ARB_BURST_EN
        burst_cnt_d = burst_cnt_q;
        if (xfer_done) begin
            if (g_addr_vld && (burst_cnt_q < BURST_W'(MAX_BURST - 1))) begin
                state_d     = ARB_SEND;
                burst_cnt_d = burst_cnt_q + BURST_W'(1);
            end else begin
                state_d     = ARB_IDLE;
                burst_cnt_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            grant_q     <= GRANT_PL;
            last_q      <= GRANT_MA;
`ifdef MEM_ARB_BURST_EN
            burst_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
`ifdef MEM_ARB_BURST_EN
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

    // Everything is gated by state, so reset (state=IDLE) forces all outputs low at once.
    always_comb begin
        mem_if.send_addr_vld = in_send ? g_addr_vld : 1'b0;
        mem_if.send_addr_dat = in_send ? g_addr     : '0;
        mem_if.send_data_vld = in_send ? g_data_vld : 1'b0;
        mem_if.send_data_dat = in_send ? g_data     : '0;
        mem_if.recv_rdy      = in_resp ? g_recv_rdy : 1'b0;

        pl_if.send_rdy = in_send && (grant_q == GRANT_PL) && mem_if.send_rdy;
        ma_if.send_rdy = in_send && (grant_q == GRANT_MA) && mem_if.send_rdy;

        pl_if.recv_vld = in_resp && (grant_q == GRANT_PL) && mem_if.recv_vld;
        ma_if.recv_vld = in_resp && (grant_q == GRANT_MA) && mem_if.recv_vld;
        pl_if.recv_dat = (in_resp && (grant_q == GRANT_PL)) ? mem_if.recv_dat : '0;
        ma_if.recv_dat = (in_resp && (grant_q == GRANT_MA)) ? mem_if.recv_dat : '0;
    end

endmodule
